// File: rtl/gcm_dl_mon_pkg.sv
// Shared types and helpers for the GCM_AE_HW_1x8 deadlock monitors.
package gcm_dl_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WATCH,
        BLOCKED
    } dl_state_e;

    // Consecutive clear cycles needed before a raised block is dropped.
    localparam int unsigned RELEASE_CYCLES = 2;

    function automatic int unsigned lowest_set_idx(input logic [31:0] vec);
        lowest_set_idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                lowest_set_idx = unsigned'(i);
            end
        end
    endfunction

endpackage

// File: rtl/gcm_ae_hw_1x8_write_stream_deadlock_monitor_if.sv
// Stall-flag inputs and deadlock report outputs of one write_stream monitor.
interface gcm_ae_hw_1x8_write_stream_deadlock_monitor_if #(
    parameter int unsigned NUM_AXIS = 7,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned IDX_W    = 3
);
    logic [NUM_AXIS-1:0] axis_block_sigs;
    logic [NUM_AXIS-1:0] inst_idle_sigs;
    logic                inst_block_sigs;
    logic                clear;
    logic                block;
    logic                block_sticky;
    logic [IDX_W-1:0]    block_idx;
    logic [CNT_W-1:0]    stall_cnt;

    modport master (
        output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
        input  block, block_sticky, block_idx, stall_cnt
    );

    modport slave (
        input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
        output block, block_sticky, block_idx, stall_cnt
    );
endinterface

// File: rtl/gcm_dl_stall_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module gcm_dl_stall_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/gcm_ae_hw_1x8_write_stream_deadlock_monitor.sv
// Write-side deadlock monitor: raises block after STALL_THRESH stalled cycles,
// latches the offending stream index and keeps a sticky flag until cleared.
module gcm_ae_hw_1x8_write_stream_deadlock_monitor
    import gcm_dl_mon_pkg::*;
#(
    parameter int unsigned         NUM_AXIS     = 7,
    parameter int unsigned         CUR_IDX      = 6,
    parameter logic [NUM_AXIS-1:0] SUB_MASK     = 7'h3C,
    parameter int unsigned         STALL_THRESH = 16,
    parameter int unsigned         CNT_W        = 8,
    parameter int unsigned         IDX_W        = 3
) (
    input logic clock,
    input logic reset,
    gcm_ae_hw_1x8_write_stream_deadlock_monitor_if.slave mon
);
    logic [NUM_AXIS-1:0] sub_vec;
    logic                cur_blk, sub_blk, seq_blk;
    logic [IDX_W-1:0]    cause;
    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W:0]      cnt_next;
    logic                thresh_hit;
    logic                cnt_clr, cnt_inc, enter_blk;
    logic                unused_idle;

    dl_state_e        state_d, state_q;
    logic             block_d, block_q;
    logic             sticky_d, sticky_q;
    logic [IDX_W-1:0] idx_d, idx_q;
    logic [1:0]       rel_d, rel_q;

    // An idle producer is never counted as blocked, even with its flag high.
    assign cur_blk     = mon.axis_block_sigs[CUR_IDX] & ~mon.inst_idle_sigs[CUR_IDX];
    assign sub_vec     = mon.axis_block_sigs & SUB_MASK;
    assign sub_blk     = |sub_vec;
    assign seq_blk     = cur_blk | sub_blk | (mon.inst_block_sigs & ~mon.inst_idle_sigs[CUR_IDX]);
    assign unused_idle = ^mon.inst_idle_sigs;

    always_comb begin
        cause = IDX_W'(CUR_IDX);
        if (!cur_blk && sub_blk) begin
            cause = IDX_W'(lowest_set_idx(32'(sub_vec)));
        end
    end

    assign cnt_next   = {1'b0, stall_cnt} + (CNT_W + 1)'(1);
    assign thresh_hit = (cnt_next == (CNT_W + 1)'(STALL_THRESH));

    gcm_dl_stall_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk_i(clock),
        .rst_i(reset),
        .clr_i(cnt_clr),
        .inc_i(cnt_inc),
        .cnt_o(stall_cnt)
    );

    always_comb begin
        state_d   = state_q;
        block_d   = block_q;
        sticky_d  = sticky_q;
        idx_d     = idx_q;
        rel_d     = rel_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        enter_blk = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Counter is zero here, so thresh_hit covers STALL_THRESH == 1.
                if (seq_blk) begin
                    cnt_inc = 1'b1;
                    if (thresh_hit) begin
                        enter_blk = 1'b1;
                    end else begin
                        state_d = WATCH;
                    end
                end else begin
                    cnt_clr = 1'b1;
                end
            end
            WATCH: begin
                if (!seq_blk) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                    if (thresh_hit) begin
                        enter_blk = 1'b1;
                    end
                end
            end
            BLOCKED: begin
                if (seq_blk) begin
                    cnt_inc = 1'b1;
                    rel_d   = '0;
                end else if (rel_q == 2'(RELEASE_CYCLES - 1)) begin
                    state_d = IDLE;
                    block_d = 1'b0;
                    cnt_clr = 1'b1;
                    rel_d   = '0;
                end else begin
                    rel_d = rel_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (mon.clear) begin
            sticky_d = 1'b0;
            idx_d    = '0;
        end
        // Entering BLOCKED overrides a coincident clear.
        if (enter_blk) begin
            state_d  = BLOCKED;
            block_d  = 1'b1;
            sticky_d = 1'b1;
            idx_d    = cause;
            rel_d    = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            block_q  <= 1'b0;
            sticky_q <= 1'b0;
            idx_q    <= '0;
            rel_q    <= '0;
        end else begin
            state_q  <= state_d;
            block_q  <= block_d;
            sticky_q <= sticky_d;
            idx_q    <= idx_d;
            rel_q    <= rel_d;
        end
    end

    assign mon.block        = block_q;
    assign mon.block_sticky = sticky_q;
    assign mon.block_idx    = idx_q;
    assign mon.stall_cnt    = stall_cnt;
endmodule

// File: tb/tb_gcm_ae_hw_1x8_write_stream_deadlock_monitor.sv
// Scoreboard bench for the write_stream deadlock monitor (default parameters).
module tb_gcm_ae_hw_1x8_write_stream_deadlock_monitor;
    localparam int THRESH = 16;

    typedef struct packed {
        logic       blk;
        logic       sticky;
        logic [2:0] idx;
        logic [7:0] cnt;
    } exp_t;

    logic  clock;
    logic  reset;
    exp_t  sb_q[$];
    int    num_cmp = 0;
    int    num_err = 0;
    string phase   = "init";

    int m_state, m_cnt, m_rel, m_idx;
    bit m_sticky;

    gcm_ae_hw_1x8_write_stream_deadlock_monitor_if #(
        .NUM_AXIS(7),
        .CNT_W(8),
        .IDX_W(3)
    ) bus ();

    gcm_ae_hw_1x8_write_stream_deadlock_monitor #(
        .NUM_AXIS(7),
        .CUR_IDX(6),
        .SUB_MASK(7'h3C),
        .STALL_THRESH(THRESH),
        .CNT_W(8),
        .IDX_W(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mon(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_cmp++;
        if (got !== exp) begin
            num_err++;
            $display("FAIL %s.%s: got %0h expected %0h", phase, tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_cnt    = 0;
        m_rel    = 0;
        m_idx    = 0;
        m_sticky = 0;
    endtask

    // Drive one cycle, push the modelled outcome, then compare after the edge.
    task automatic step(input logic [6:0] ab, input logic [6:0] idl, input logic ib,
                        input logic clr);
        exp_t       e;
        logic       cur, seq;
        logic [6:0] sv;
        int         cause;
        bit         enter;
        bus.axis_block_sigs = ab;
        bus.inst_idle_sigs  = idl;
        bus.inst_block_sigs = ib;
        bus.clear           = clr;
        cur   = ab[6] & ~idl[6];
        sv    = ab & 7'h3C;
        seq   = cur | (|sv) | (ib & ~idl[6]);
        cause = 6;
        if (!cur) begin
            for (int i = 6; i >= 0; i--) begin
                if (sv[i]) cause = i;
            end
        end
        enter = 0;
        case (m_state)
            0: if (seq) begin
                m_cnt = 1;
                if (m_cnt == THRESH) enter = 1;
                else m_state = 1;
            end
            1: if (!seq) begin
                m_state = 0;
                m_cnt   = 0;
            end else begin
                m_cnt++;
                if (m_cnt == THRESH) enter = 1;
            end
            default: if (seq) begin
                m_rel = 0;
                if (m_cnt < 255) m_cnt++;
            end else begin
                m_rel++;
                if (m_rel == 2) begin
                    m_state = 0;
                    m_rel   = 0;
                    m_cnt   = 0;
                end
            end
        endcase
        if (clr) begin
            m_sticky = 0;
            m_idx    = 0;
        end
        if (enter) begin
            m_state  = 2;
            m_rel    = 0;
            m_sticky = 1;
            m_idx    = cause;
        end
        e.blk    = (m_state == 2);
        e.sticky = m_sticky;
        e.idx    = 3'(m_idx);
        e.cnt    = 8'(m_cnt);
        sb_q.push_back(e);

        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        check_eq("block", 32'(bus.block), 32'(e.blk));
        check_eq("sticky", 32'(bus.block_sticky), 32'(e.sticky));
        check_eq("idx", 32'(bus.block_idx), 32'(e.idx));
        check_eq("cnt", 32'(bus.stall_cnt), 32'(e.cnt));
    endtask

    task automatic hold(input int n, input logic [6:0] ab, input logic [6:0] idl,
                        input logic ib);
        for (int i = 0; i < n; i++) step(ab, idl, ib, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".block"}, 32'(bus.block), 32'd0);
        check_eq({tag, ".sticky"}, 32'(bus.block_sticky), 32'd0);
        check_eq({tag, ".idx"}, 32'(bus.block_idx), 32'd0);
        check_eq({tag, ".cnt"}, 32'(bus.stall_cnt), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        reset               = 1'b1;
        bus.axis_block_sigs = '0;
        bus.inst_idle_sigs  = '0;
        bus.inst_block_sigs = 1'b0;
        bus.clear           = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        phase = "reset";
        check_all_zero("rst");
        reset = 1'b0;

        phase = "thresh";
        hold(15, 7'h40, 7'h00, 1'b0);
        check_eq("block_at15", 32'(bus.block), 32'd0);
        hold(1, 7'h40, 7'h00, 1'b0);
        check_eq("block_at16", 32'(bus.block), 32'd1);
        hold(4, 7'h40, 7'h00, 1'b0);
        check_eq("cnt_at20", 32'(bus.stall_cnt), 32'd20);
        check_eq("idx_own", 32'(bus.block_idx), 32'd6);

        phase = "release";
        hold(2, 7'h00, 7'h00, 1'b0);
        check_eq("block_off", 32'(bus.block), 32'd0);
        check_eq("sticky_kept", 32'(bus.block_sticky), 32'd1);

        phase = "idle_mask";
        hold(40, 7'h40, 7'h40, 1'b0);
        check_eq("block", 32'(bus.block), 32'd0);
        check_eq("cnt", 32'(bus.stall_cnt), 32'd0);

        phase = "sub";
        hold(20, 7'h28, 7'h00, 1'b0);
        check_eq("idx_low", 32'(bus.block_idx), 32'd3);
        hold(1, 7'h00, 7'h00, 1'b0);
        hold(3, 7'h28, 7'h00, 1'b0);
        check_eq("glitch_hold", 32'(bus.block), 32'd1);
        hold(2, 7'h00, 7'h00, 1'b0);
        check_eq("block_off", 32'(bus.block), 32'd0);
        check_eq("sticky_kept", 32'(bus.block_sticky), 32'd1);

        phase = "clr_vs_set";
        hold(15, 7'h20, 7'h00, 1'b0);
        step(7'h20, 7'h00, 1'b0, 1'b1);
        check_eq("sticky_set_wins", 32'(bus.block_sticky), 32'd1);
        check_eq("idx_set_wins", 32'(bus.block_idx), 32'd5);
        hold(2, 7'h00, 7'h00, 1'b0);

        phase = "clear";
        step(7'h00, 7'h00, 1'b0, 1'b1);
        check_eq("sticky", 32'(bus.block_sticky), 32'd0);
        check_eq("idx", 32'(bus.block_idx), 32'd0);

        phase = "inst_blk";
        hold(16, 7'h00, 7'h00, 1'b1);
        check_eq("block", 32'(bus.block), 32'd1);
        check_eq("idx", 32'(bus.block_idx), 32'd6);
        hold(2, 7'h00, 7'h00, 1'b0);

        phase = "saturate";
        hold(300, 7'h40, 7'h00, 1'b0);
        check_eq("cnt_sat", 32'(bus.stall_cnt), 32'd255);
        hold(2, 7'h00, 7'h00, 1'b0);

        phase = "async_rst";
        hold(150, 7'h40, 7'h00, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("arst");
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;

        phase = "restart";
        hold(3, 7'h40, 7'h00, 1'b0);
        check_eq("cnt_restart", 32'(bus.stall_cnt), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_err);
        $finish;
    end
endmodule
